// File: rtl/bus_split_arbiter.sv
// Registered arbiter for the dual-master bus with split-transaction parking.
// The state code doubles as the bus_sel mux select.
module bus_split_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int SPLIT_TIMEOUT = 256,
   parameter int CNT_W         = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       m1_req,
   input  logic       m2_req,
   input  logic       split_s_req,
   input  logic       split_ack_in,
   output logic       m1_grant,
   output logic       m2_grant,
   output logic       split_s_grant,
   output logic [1:0] bus_sel,
   output logic       split_pending,
   output logic       split_master,
   output logic       split_timeout
);

   localparam logic [1:0] IDLE      = 2'b00;
   localparam logic [1:0] M1_OWN    = 2'b01;
   localparam logic [1:0] M2_OWN    = 2'b10;
   localparam logic [1:0] SPLIT_RET = 2'b11;

   localparam logic             TO_EN       = (SPLIT_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(SPLIT_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   logic [1:0]       state_q, state_d;
   logic             pending_q, pending_d;
   logic             master_q, master_d;
   logic             timeout_q, timeout_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             m1_elig, m2_elig;
   logic             cnt_run, timeout_hit;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      m1_elig     = m1_req && !(pending_q && !master_q);
      m2_elig     = m2_req && !(pending_q && master_q);
      cnt_run     = pending_q && (state_q != SPLIT_RET);
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      timeout_hit = TO_EN && cnt_run && (cnt_inc == TIMEOUT_VAL);

      state_d   = state_q;
      pending_d = pending_q;
      master_d  = master_q;
      last_d    = last_q;
      timeout_d = 1'b0;
      cnt_d     = cnt_q;

      if (cnt_run) begin
         cnt_d = cnt_inc;
      end
      // An abandoned split must not also start a data return in the same cycle.
      if (timeout_hit) begin
         timeout_d = 1'b1;
         pending_d = 1'b0;
         cnt_d     = '0;
      end

      case (state_q)
         IDLE: begin
            if (pending_q && !timeout_hit && split_s_req) begin
               state_d = SPLIT_RET;
            end else if (m1_elig && m2_elig) begin
               state_d = ((PRIORITY_MODE == 0) || last_q) ? M1_OWN : M2_OWN;
            end else if (m1_elig) begin
               state_d = M1_OWN;
            end else if (m2_elig) begin
               state_d = M2_OWN;
            end
         end
         M1_OWN: begin
            if (split_ack_in && !pending_q) begin
               pending_d = 1'b1;
               master_d  = 1'b0;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (!m1_req) begin
               last_d  = 1'b0;
               state_d = IDLE;
            end
         end
         M2_OWN: begin
            if (split_ack_in && !pending_q) begin
               pending_d = 1'b1;
               master_d  = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (!m2_req) begin
               last_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            if (!split_s_req) begin
               pending_d = 1'b0;
               state_d   = IDLE;
            end
         end
      endcase
   end

   // last_q resets to m2 so that m1 wins the first round-robin tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         master_q  <= 1'b0;
         timeout_q <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         master_q  <= master_d;
         timeout_q <= timeout_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign m1_grant      = (state_q == M1_OWN);
   assign m2_grant      = (state_q == M2_OWN);
   assign split_s_grant = (state_q == SPLIT_RET);
   assign bus_sel       = state_q;
   assign split_pending = pending_q;
   assign split_master  = master_q;
   assign split_timeout = timeout_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Directed bench for bus_split_arbiter: a fixed-priority instance and a round-robin
// instance share stimulus; observations are packed as {m1g,m2g,sg,bus_sel,pend,master,timeout}.
module tb_bus_split_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic m1_req, m2_req, split_s_req, split_ack_in;

   logic       a_m1g, a_m2g, a_sg, a_sp, a_sm, a_st;
   logic [1:0] a_sel;
   logic       b_m1g, b_m2g, b_sg, b_sp, b_sm, b_st;
   logic [1:0] b_sel;

   int nChecks = 0;
   int nFails  = 0;
   logic [7:0] exp;

   always #5 clk = ~clk;

   bus_split_arbiter #(.PRIORITY_MODE(0), .SPLIT_TIMEOUT(8), .CNT_W(4)) dutFixed (
      .clk(clk), .rst_n(rst_n), .m1_req(m1_req), .m2_req(m2_req),
      .split_s_req(split_s_req), .split_ack_in(split_ack_in),
      .m1_grant(a_m1g), .m2_grant(a_m2g), .split_s_grant(a_sg), .bus_sel(a_sel),
      .split_pending(a_sp), .split_master(a_sm), .split_timeout(a_st)
   );

   bus_split_arbiter #(.PRIORITY_MODE(1), .SPLIT_TIMEOUT(8), .CNT_W(4)) dutRr (
      .clk(clk), .rst_n(rst_n), .m1_req(m1_req), .m2_req(m2_req),
      .split_s_req(split_s_req), .split_ack_in(split_ack_in),
      .m1_grant(b_m1g), .m2_grant(b_m2g), .split_s_grant(b_sg), .bus_sel(b_sel),
      .split_pending(b_sp), .split_master(b_sm), .split_timeout(b_st)
   );

   function automatic logic [7:0] obsA();
      return {a_m1g, a_m2g, a_sg, a_sel, a_sp, a_sm, a_st};
   endfunction

   function automatic logic [7:0] obsB();
      return {b_m1g, b_m2g, b_sg, b_sel, b_sp, b_sm, b_st};
   endfunction

   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m1_req = 1'b0; m2_req = 1'b0; split_s_req = 1'b0; split_ack_in = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m1_req = 1'b1; m2_req = 1'b1; split_s_req = 1'b1; split_ack_in = 1'b1;
      cycle();
      cycle();
      exp = 8'b000_00_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL reset_fixed got %b exp %b", obsA(), exp); end
      nChecks++;
      if (obsB() !== exp) begin nFails++; $display("[TB] FAIL reset_rr got %b exp %b", obsB(), exp); end
      nChecks++;
      m1_req = 1'b0; m2_req = 1'b0; split_s_req = 1'b0; split_ack_in = 1'b0;
      rst_n = 1'b1;
      cycle();
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL reset_idle got %b exp %b", obsA(), exp); end
      nChecks++;
   endtask

   task automatic test_single_master();
      do_reset();
      m2_req = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cycle();
         exp = 8'b010_10_000;
         if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_own_c%0d got %b exp %b", i, obsA(), exp); end
         nChecks++;
      end
      m2_req = 1'b0;
      cycle();
      exp = 8'b000_00_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_release got %b exp %b", obsA(), exp); end
      nChecks++;
   endtask

   task automatic test_fixed_priority();
      do_reset();
      m1_req = 1'b1; m2_req = 1'b1;
      cycle();
      exp = 8'b100_01_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL tie_fixed got %b exp %b", obsA(), exp); end
      nChecks++;
      if (obsB() !== exp) begin nFails++; $display("[TB] FAIL tie_rr_first got %b exp %b", obsB(), exp); end
      nChecks++;
      m1_req = 1'b0;
      cycle();
      exp = 8'b000_00_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL gap_idle got %b exp %b", obsA(), exp); end
      nChecks++;
      cycle();
      exp = 8'b010_10_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_after_m1 got %b exp %b", obsA(), exp); end
      nChecks++;
      m2_req = 1'b0;
      cycle();
   endtask

   task automatic test_round_robin();
      do_reset();
      m1_req = 1'b1; m2_req = 1'b1;
      cycle();
      m1_req = 1'b0;
      cycle();
      m1_req = 1'b1;
      cycle();
      exp = 8'b100_01_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL burst2_fixed got %b exp %b", obsA(), exp); end
      nChecks++;
      exp = 8'b010_10_000;
      if (obsB() !== exp) begin nFails++; $display("[TB] FAIL burst2_rr got %b exp %b", obsB(), exp); end
      nChecks++;
      m1_req = 1'b0; m2_req = 1'b0;
      cycle();
   endtask

   task automatic test_split_park();
      do_reset();
      m2_req = 1'b1;
      cycle();
      split_ack_in = 1'b1;
      cycle();
      exp = 8'b000_00_110;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL split_ack got %b exp %b", obsA(), exp); end
      nChecks++;
      split_ack_in = 1'b0; m1_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         exp = 8'b100_01_110;
         if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_masked_c%0d got %b exp %b", i, obsA(), exp); end
         nChecks++;
      end
      m1_req = 1'b0;
      cycle();
      exp = 8'b000_00_110;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL parked_idle got %b exp %b", obsA(), exp); end
      nChecks++;
      split_s_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         exp = 8'b001_11_110;
         if (obsA() !== exp) begin nFails++; $display("[TB] FAIL split_ret_c%0d got %b exp %b", i, obsA(), exp); end
         nChecks++;
      end
      split_s_req = 1'b0;
      cycle();
      exp = 8'b000_00_010;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL ret_done got %b exp %b", obsA(), exp); end
      nChecks++;
      cycle();
      exp = 8'b010_10_010;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_regrant got %b exp %b", obsA(), exp); end
      nChecks++;
      m2_req = 1'b0;
      cycle();
   endtask

   task automatic test_split_timeout();
      do_reset();
      m2_req = 1'b1;
      cycle();
      split_ack_in = 1'b1;
      cycle();
      split_ack_in = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         cycle();
         exp = 8'b000_00_110;
         if (obsA() !== exp) begin nFails++; $display("[TB] FAIL to_wait_c%0d got %b exp %b", k, obsA(), exp); end
         nChecks++;
      end
      cycle();
      exp = 8'b000_00_011;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL to_pulse got %b exp %b", obsA(), exp); end
      nChecks++;
      cycle();
      exp = 8'b010_10_010;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL to_regrant got %b exp %b", obsA(), exp); end
      nChecks++;
      m2_req = 1'b0;
      cycle();
   endtask

   task automatic test_split_priority();
      do_reset();
      m1_req = 1'b1;
      cycle();
      split_ack_in = 1'b1;
      cycle();
      split_ack_in = 1'b0; m2_req = 1'b1; split_s_req = 1'b1;
      cycle();
      exp = 8'b001_11_100;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL split_wins got %b exp %b", obsA(), exp); end
      nChecks++;
      split_s_req = 1'b0; m1_req = 1'b0; m2_req = 1'b0;
      cycle();
      exp = 8'b000_00_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL ret_clear got %b exp %b", obsA(), exp); end
      nChecks++;
      split_s_req = 1'b1; split_ack_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         if (obsA() !== exp) begin nFails++; $display("[TB] FAIL spurious_c%0d got %b exp %b", i, obsA(), exp); end
         nChecks++;
      end
      split_s_req = 1'b0; split_ack_in = 1'b0;
      cycle();
   endtask

   task automatic test_double_split();
      do_reset();
      m1_req = 1'b1;
      cycle();
      split_ack_in = 1'b1;
      cycle();
      split_ack_in = 1'b0; m2_req = 1'b1;
      cycle();
      exp = 8'b010_10_100;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_while_pend got %b exp %b", obsA(), exp); end
      nChecks++;
      split_ack_in = 1'b1;
      cycle();
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL second_ack got %b exp %b", obsA(), exp); end
      nChecks++;
      split_ack_in = 1'b0; m2_req = 1'b0; m1_req = 1'b0;
      cycle();
      exp = 8'b000_00_100;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL m2_done got %b exp %b", obsA(), exp); end
      nChecks++;
   endtask

   task automatic test_reset_async();
      do_reset();
      m1_req = 1'b1;
      cycle();
      split_ack_in = 1'b1;
      cycle();
      split_ack_in = 1'b0; m1_req = 1'b0; split_s_req = 1'b1;
      cycle();
      exp = 8'b001_11_100;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL pre_reset_ret got %b exp %b", obsA(), exp); end
      nChecks++;
      #2 rst_n = 1'b0;
      #1;
      exp = 8'b000_00_000;
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL async_drop got %b exp %b", obsA(), exp); end
      nChecks++;
      cycle();
      rst_n = 1'b1;
      cycle();
      if (obsA() !== exp) begin nFails++; $display("[TB] FAIL post_reset got %b exp %b", obsA(), exp); end
      nChecks++;
      split_s_req = 1'b0;
      cycle();
   endtask

   initial begin
      test_reset();
      test_single_master();
      test_fixed_priority();
      test_round_robin();
      test_split_park();
      test_split_timeout();
      test_split_priority();
      test_double_split();
      test_reset_async();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/bus_split_arbiter.md
Name: bus_split_arbiter

Overview:
- Registered arbiter and sequencer for the dual-master system bus.
- Shares the bus between master 1 and master 2, and parks a master whose transaction the split slave defers with split-ack.
- Returns bus ownership to the split slave when it raises split_s_req to deliver deferred read data.
- Drives the grant lines and the bus_sel code that steers the bus address/data muxes.

Parameters:
PRIORITY_MODE, 0, 0 = fixed priority (m1 wins ties); 1 = round-robin (master not served last wins ties)
SPLIT_TIMEOUT, 256, cycles a split may stay pending before it is abandoned; 0 disables the timeout
CNT_W, 9, width of the split timeout counter; must satisfy 2^CNT_W > SPLIT_TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
m1_req  input  1  master 1 bus request, held for the whole transaction
m2_req  input  1  master 2 bus request, held for the whole transaction
split_s_req  input  1  split slave request to return deferred data
split_ack_in  input  1  split-ack from the currently addressed split slave
m1_grant  output  1  bus granted to master 1
m2_grant  output  1  bus granted to master 2
split_s_grant  output  1  bus granted to split slave for data return
bus_sel  output  2  mux select: 00 idle, 01 m1, 10 m2, 11 split return
split_pending  output  1  a split transaction is outstanding
split_master  output  1  owner of the pending split: 0 = m1, 1 = m2
split_timeout  output  1  one-cycle pulse when a pending split is abandoned

Behaviour:
- Reset (asynchronous, on rst_n low):
  - state = IDLE.
  - All grants = 0, bus_sel = 00.
  - split_pending, split_master, split_timeout = 0.
  - Timeout counter = 0; round-robin last-served pointer = m2, so m1 wins the first tie.
  - Reset mid-transaction drops all grants immediately and discards any pending split.
- States: IDLE, M1_OWN, M2_OWN, SPLIT_RET. All outputs are registered and decoded from state.
  - Exactly one grant is high outside IDLE; none is high in IDLE.
  - bus_sel matches the active grant.
- Eligibility: a master is eligible when its req is high and it is not the split_master of a pending split. A parked master's req is masked.
- IDLE, evaluated each cycle in this order:
  1. split_pending && split_s_req: go to SPLIT_RET.
  2. Otherwise the eligible master(s) are arbitrated per PRIORITY_MODE, and the winner's state is entered.
  3. Otherwise stay in IDLE.
  - Grant appears the cycle after req is sampled high (1-cycle latency).
- M1_OWN / M2_OWN, evaluated each cycle in this order:
  1. split_ack_in high: set split_pending = 1, latch split_master = owner, clear the timeout counter, go to IDLE.
  2. Otherwise, owner req low: go to IDLE and update the last-served pointer.
  3. Otherwise hold.
  - split_ack_in and req drop in the same cycle: split takes precedence.
  - No back-to-back handover; at least one IDLE cycle always separates owners.
- SPLIT_RET:
  - split_s_grant = 1, bus_sel = 11. The bus routes return data to split_master.
  - Hold while split_s_req is high.
  - On split_s_req low: clear split_pending, go to IDLE. The parked master becomes eligible again.
- split_ack_in outside M1_OWN/M2_OWN is ignored. split_s_req with no pending split is ignored, with no grant.
- Only one split may be outstanding. split_ack_in while split_pending is already set is ignored; the owner then continues normally.
- Timeout counter:
  - Increments each cycle while split_pending is set and state != SPLIT_RET. It freezes in SPLIT_RET.
  - When the count reaches SPLIT_TIMEOUT (nonzero) in IDLE, M1_OWN or M2_OWN: pulse split_timeout for 1 cycle, clear split_pending, reset the counter.
  - The counter saturates and never wraps.
- Simultaneous split_s_req and master requests in IDLE: split return always wins.

Test Plan:
- Reset, then m2_req=1 at cycle 0 -> m2_grant=1 and bus_sel=10 from cycle 1; m2_req drops at cycle 5 -> m2_grant=0, bus_sel=00 at cycle 6; m1 grant never asserted.
- PRIORITY_MODE=0, m1_req and m2_req rise together -> m1_grant first; after m1 releases, one IDLE cycle, then m2_grant. PRIORITY_MODE=1, second simultaneous burst -> m2 served first.
- m2 owns bus, split_ack_in pulse -> split_pending=1, split_master=1, m2_grant=0 next cycle. m2_req stays high and m1_req=1 -> m1 granted, m2 masked. After m1 releases, split_s_req=1 -> split_s_grant=1, bus_sel=11. split_s_req drops -> split_pending=0, then m2 regranted.
- SPLIT_TIMEOUT=8, split pending with no split_s_req -> split_timeout pulses exactly once 8 cycles after split_ack_in; split_pending=0; m2 eligible the next cycle.
- Split return and master request both in IDLE in the same cycle -> split_s_grant wins; a later split_s_req with split_pending=0 -> no grant.
- Assert rst_n=0 during SPLIT_RET -> all grants and split_pending drop without waiting for clk; after release, state is IDLE and bus_sel=00.
